// File: rtl/tabla_checker.sv
// tabla_checker: collects (input vector, observed Y) samples from a DUT sweep,
// records one Y per combination, compares it with an expected truth table and
// reports pass/fail once every combination has been seen.
module tabla_checker #(
    parameter int                 N_IN     = 3,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'b1001_0110
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 in_y,
    output logic                 in_ready,
    output logic [2**N_IN-1:0]   captured,
    output logic [2**N_IN-1:0]   seen,
    output logic [N_IN:0]        err_count,
    output logic                 mismatch,
    output logic                 first_err_valid,
    output logic [N_IN-1:0]      first_err_vec,
    output logic                 dup,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    localparam int            NUM     = 2**N_IN;
    localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM-1:0]      captured_q, captured_d;
    logic [NUM-1:0]      seen_q, seen_d;
    logic [N_IN:0]       err_count_q, err_count_d;
    logic                mismatch_q, mismatch_d;
    logic                first_err_valid_q, first_err_valid_d;
    logic [N_IN-1:0]     first_err_vec_q, first_err_vec_d;
    logic                dup_q, dup_d;

    // Next-state and result update; start wins over everything and opens a fresh run.
    always_comb begin
        state_d           = state_q;
        captured_d        = captured_q;
        seen_d            = seen_q;
        err_count_d       = err_count_q;
        mismatch_d        = 1'b0;
        first_err_valid_d = first_err_valid_q;
        first_err_vec_d   = first_err_vec_q;
        dup_d             = dup_q;

        if (start) begin
            // Any state: clear the results and (re)enter RUN; a sample offered now is dropped.
            state_d           = ST_RUN;
            captured_d        = '0;
            seen_d            = '0;
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_vec_d   = '0;
            dup_d             = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (in_valid) begin
                        if (!seen_q[in_vec]) begin
                            seen_d[in_vec]     = 1'b1;
                            captured_d[in_vec] = in_y;
                            if (in_y != EXPECTED[in_vec]) begin
                                if (err_count_q != ERR_MAX) begin
                                    err_count_d = err_count_q + (N_IN+1)'(1);
                                end
                                mismatch_d = 1'b1;
                                if (!first_err_valid_q) begin
                                    first_err_valid_d = 1'b1;
                                    first_err_vec_d   = in_vec;
                                end
                            end
                        end else begin
                            dup_d = 1'b1;
                        end
                        if (&seen_d) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            captured_q        <= '0;
            seen_q            <= '0;
            err_count_q       <= '0;
            mismatch_q        <= 1'b0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= '0;
            dup_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            captured_q        <= captured_d;
            seen_q            <= seen_d;
            err_count_q       <= err_count_d;
            mismatch_q        <= mismatch_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_vec_q   <= first_err_vec_d;
            dup_q             <= dup_d;
        end
    end

    // Outputs come straight from registers or the current state; pass adds no latency.
    always_comb begin
        in_ready        = (state_q == ST_RUN);
        busy            = (state_q == ST_RUN);
        done            = (state_q == ST_DONE);
        pass            = (state_q == ST_DONE) && (err_count_q == '0);
        captured        = captured_q;
        seen            = seen_q;
        err_count       = err_count_q;
        mismatch        = mismatch_q;
        first_err_valid = first_err_valid_q;
        first_err_vec   = first_err_vec_q;
        dup             = dup_q;
    end

endmodule

// File: tb/tb_tabla_checker.sv
// tb_tabla_checker: randomized scoreboard bench; expected results come from a
// set-based reference model of the checker rules (3-input XOR truth table).
module tb_tabla_checker;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_vec = '0;
    logic       in_y = 1'b0;
    logic       in_ready;
    logic [7:0] captured;
    logic [7:0] seen;
    logic [3:0] err_count;
    logic       mismatch;
    logic       first_err_valid;
    logic [2:0] first_err_vec;
    logic       dup;
    logic       busy;
    logic       done;
    logic       pass;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] cap;
        logic [7:0] seen;
        logic [3:0] err;
        logic       mm;
        logic       fev;
        logic [2:0] fvec;
        logic       dup;
        logic       busy;
        logic       done;
        logic       pass;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: what has been seen, what was recorded, and the run phase.
    bit m_cap[8];
    bit m_seen[8];
    int m_err;
    bit m_fev;
    int m_fvec;
    bit m_dup;
    int m_phase;   // 0 idle, 1 running, 2 finished

    tabla_checker dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_vec(in_vec),
        .in_y(in_y),
        .in_ready(in_ready),
        .captured(captured),
        .seen(seen),
        .err_count(err_count),
        .mismatch(mismatch),
        .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec),
        .dup(dup),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    // Gated clock so reset can be exercised with no clock activity.
    always #5 if (clk_en) clk = ~clk;

    // Expected Y is odd parity of the input combination.
    function automatic bit ref_y(int v);
        return bit'($countones(v & 7) % 2);
    endfunction

    function automatic exp_t snapshot(bit mm);
        exp_t e;
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            e.cap[i]  = m_cap[i];
            e.seen[i] = m_seen[i];
        end
        e.err  = 4'(m_err);
        e.mm   = mm;
        e.fev  = m_fev;
        e.fvec = 3'(m_fvec);
        e.dup  = m_dup;
        e.busy = (m_phase == 1);
        e.done = (m_phase == 2);
        e.pass = (m_phase == 2) && (m_err == 0);
        e.rdy  = (m_phase == 1);
        return e;
    endfunction

    task automatic model_clear(int phase_after);
        for (int i = 0; i < 8; i++) begin
            m_cap[i]  = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_err   = 0;
        m_fev   = 1'b0;
        m_fvec  = 0;
        m_dup   = 1'b0;
        m_phase = phase_after;
    endtask

    task automatic model_accept(int v, bit y, output bit mm);
        int cnt;
        mm = 1'b0;
        if (!m_seen[v]) begin
            m_seen[v] = 1'b1;
            m_cap[v]  = y;
            if (y != ref_y(v)) begin
                m_err++;
                mm = 1'b1;
                if (!m_fev) begin
                    m_fev  = 1'b1;
                    m_fvec = v;
                end
            end
        end else begin
            m_dup = 1'b1;
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(m_seen[i]);
        if (cnt == 8) m_phase = 2;
    endtask

    task automatic check_field(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(string tag, exp_t e);
        check_field({tag, ".captured"}, 32'(captured), 32'(e.cap));
        check_field({tag, ".seen"}, 32'(seen), 32'(e.seen));
        check_field({tag, ".err_count"}, 32'(err_count), 32'(e.err));
        check_field({tag, ".mismatch"}, 32'(mismatch), 32'(e.mm));
        check_field({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(e.fev));
        check_field({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(e.fvec));
        check_field({tag, ".dup"}, 32'(dup), 32'(e.dup));
        check_field({tag, ".busy"}, 32'(busy), 32'(e.busy));
        check_field({tag, ".done"}, 32'(done), 32'(e.done));
        check_field({tag, ".pass"}, 32'(pass), 32'(e.pass));
        check_field({tag, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
    endtask

    // Monitor: an accept seen before an edge pops one expectation, checked just after it.
    initial begin : monitor
        bit   hs;
        exp_t e;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready && !start && rst_n;
            @(posedge clk);
            #1;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check_field("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("accept", e);
                end
            end else begin
                check_field("mismatch_idle", 32'(mismatch), 32'd0);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #2;
    endtask

    // Offer one sample and hold it until the handshake completes.
    task automatic apply_stimulus(int v, bit y);
        int waitc;
        bit mm;
        in_valid = 1'b1;
        in_vec   = 3'(v);
        in_y     = y;
        waitc    = 0;
        @(negedge clk);
        while (!in_ready && waitc < 20) begin
            waitc++;
            @(negedge clk);
        end
        check_field("send_ready", 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        model_accept(v, y, mm);
        exp_q.push_back(snapshot(mm));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        model_clear(1);
        check_output("start", snapshot(1'b0));
    endtask

    task automatic reset_no_clock(string tag);
        @(negedge clk);
        #1;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        #2;
        model_clear(0);
        check_output(tag, snapshot(1'b0));
        #5;
        rst_n = 1'b1;
        #5;
        clk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic full_sweep(string tag);
        for (int v = 0; v < 8; v++) apply_stimulus(v, ref_y(v));
        idle_cycle();
        check_output(tag, snapshot(1'b0));
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        int perm[8];
        int j;
        int t;
        // Power-on reset with the clock stopped.
        model_clear(0);
        #1 rst_n = 1'b0;
        #1 check_output("por", snapshot(1'b0));
        #3 rst_n = 1'b1;
        #2 clk_en = 1'b1;
        @(posedge clk);
        #2;

        // Clean ordered sweep.
        start_run();
        full_sweep("clean");
        check_field("clean.captured_table", 32'(captured), 32'h96);

        // Offers while finished are ignored.
        in_valid = 1'b1;
        in_vec   = 3'd3;
        in_y     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_field("done.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        check_output("done_hold", snapshot(1'b0));

        // Fault injection on vectors 5 and 6, restarting from the finished state.
        start_run();
        for (int v = 0; v < 8; v++)
            apply_stimulus(v, (v == 5 || v == 6) ? !ref_y(v) : ref_y(v));
        idle_cycle();
        check_output("fault", snapshot(1'b0));

        // Duplicate vector 2 with a contradicting second Y.
        start_run();
        apply_stimulus(2, 1'b1);
        apply_stimulus(2, 1'b0);
        for (int v = 0; v < 8; v++) if (v != 2) apply_stimulus(v, ref_y(v));
        idle_cycle();
        check_output("dup", snapshot(1'b0));

        // Reverse order with idle gaps.
        start_run();
        for (int v = 7; v >= 0; v--) begin
            apply_stimulus(v, ref_y(v));
            idle_cycle();
        end
        check_output("reverse", snapshot(1'b0));

        // Reset in the middle of a run, then a complete new run.
        start_run();
        for (int v = 0; v < 4; v++) apply_stimulus(v, ref_y(v));
        reset_no_clock("midrun_reset");
        start_run();
        full_sweep("after_reset");

        // Restart in the middle of a run.
        start_run();
        for (int v = 0; v < 3; v++) apply_stimulus(v, !ref_y(v));
        start_run();
        full_sweep("restart");

        // Randomized runs: shuffled order, injected errors, duplicates and gaps.
        for (int r = 0; r < 8; r++) begin
            start_run();
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int k = 0; k < 8; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0)
                    apply_stimulus(perm[$urandom_range(0, k - 1)], 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) idle_cycle();
                apply_stimulus(perm[k], ref_y(perm[k]) ^ ($urandom_range(0, 3) == 0));
            end
            idle_cycle();
            check_output("random", snapshot(1'b0));
        end

        repeat (3) idle_cycle();
        check_field("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
